// File: rtl/equiv_lockstep_checker.sv
// Lockstep golden-vs-netlist equivalence checker: drives LFSR stimulus and reset
// into two design copies, compares their outputs and records the first failure.
module equiv_lockstep_checker #(
  parameter int          IN_WIDTH      = 32,
  parameter int          OUT_WIDTH     = 32,
  parameter int          NUM_VECTORS   = 1000,
  parameter int          HOLD_CYCLES   = 2,
  parameter int          SETTLE_CYCLES = 2,
  parameter int          CNT_WIDTH     = 16,
  parameter logic [31:0] LFSR_SEED     = 32'h1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 dut_rst,
  output logic [IN_WIDTH-1:0]  stim,
  input  logic [OUT_WIDTH-1:0] golden_out,
  input  logic [OUT_WIDTH-1:0] netlist_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_WIDTH-1:0] mismatch_count,
  output logic [CNT_WIDTH-1:0] compare_count,
  output logic                 first_fail_valid,
  output logic [CNT_WIDTH-1:0] first_fail_index,
  output logic [OUT_WIDTH-1:0] first_golden,
  output logic [OUT_WIDTH-1:0] first_netlist
);
  // state  | meaning
  // IDLE   | waiting for start, DUT copies held in reset
  // SETTLE | DUT reset held, reset compare on the last cycle
  // APPLY  | each vector held HOLD_CYCLES, compared on the last hold cycle
  // DONE   | results stable, DUT reset reasserted, start reruns
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_APPLY, S_DONE} state_t;

  localparam logic [31:0]          SEED    = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [IN_WIDTH-1:0] replicate(input logic [31:0] l);
    logic [IN_WIDTH-1:0] s;
    for (int i = 0; i < IN_WIDTH; i++) s[i] = l[i % 32];
    return s;
  endfunction

  state_t                 state_q, state_d;
  logic [31:0]            cyc_q, cyc_d;
  logic [31:0]            vec_left_q, vec_left_d;
  logic [31:0]            lfsr_q, lfsr_d;
  logic                   dut_rst_q, dut_rst_d;
  logic [IN_WIDTH-1:0]    stim_q, stim_d;
  logic                   pass_q, pass_d;
  logic [CNT_WIDTH-1:0]   mm_q, mm_d, cc_q, cc_d, idx_q, idx_d, ff_idx_q, ff_idx_d;
  logic                   ffv_q, ffv_d;
  logic [OUT_WIDTH-1:0]   fg_q, fg_d, fn_q, fn_d;
  logic                   do_cmp, go_run;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    vec_left_d = vec_left_q;
    lfsr_d     = lfsr_q;
    dut_rst_d  = dut_rst_q;
    stim_d     = stim_q;
    pass_d     = pass_q;
    mm_d       = mm_q;
    cc_d       = cc_q;
    idx_d      = idx_q;
    ffv_d      = ffv_q;
    ff_idx_d   = ff_idx_q;
    fg_d       = fg_q;
    fn_d       = fn_q;
    do_cmp     = 1'b0;
    go_run     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: go_run = start;
      S_SETTLE: begin
        if (cyc_q == 32'd0) begin
          do_cmp     = 1'b1;
          state_d    = S_APPLY;
          dut_rst_d  = 1'b0;
          stim_d     = replicate(lfsr_q);
          lfsr_d     = lfsr_next(lfsr_q);
          cyc_d      = 32'(HOLD_CYCLES - 1);
          vec_left_d = 32'(NUM_VECTORS - 1);
          idx_d      = CNT_WIDTH'(1);
        end else begin
          cyc_d = cyc_q - 32'd1;
        end
      end
      S_APPLY: begin
        if (cyc_q == 32'd0) begin
          do_cmp = 1'b1;
          if (vec_left_q == 32'd0) begin
            state_d   = S_DONE;
            dut_rst_d = 1'b1;
            stim_d    = '0;
          end else begin
            vec_left_d = vec_left_q - 32'd1;
            idx_d      = idx_q + CNT_WIDTH'(1);
            stim_d     = replicate(lfsr_q);
            lfsr_d     = lfsr_next(lfsr_q);
            cyc_d      = 32'(HOLD_CYCLES - 1);
          end
        end else begin
          cyc_d = cyc_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Compare sees the index of the vector being retired, not the next one.
    if (do_cmp) begin
      if (cc_q != CNT_MAX) cc_d = cc_q + CNT_WIDTH'(1);
      if (golden_out != netlist_out) begin
        if (mm_q != CNT_MAX) mm_d = mm_q + CNT_WIDTH'(1);
        if (!ffv_q) begin
          ffv_d    = 1'b1;
          ff_idx_d = idx_q;
          fg_d     = golden_out;
          fn_d     = netlist_out;
        end
      end
      if (state_d == S_DONE) pass_d = (mm_d == '0);
    end

    if (go_run) begin
      state_d   = S_SETTLE;
      cyc_d     = 32'(SETTLE_CYCLES - 1);
      dut_rst_d = 1'b1;
      stim_d    = '0;
      lfsr_d    = SEED;
      pass_d    = 1'b0;
      mm_d      = '0;
      cc_d      = '0;
      idx_d     = '0;
      ffv_d     = 1'b0;
      ff_idx_d  = '0;
      fg_d      = '0;
      fn_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      vec_left_q <= '0;
      lfsr_q     <= SEED;
      dut_rst_q  <= 1'b1;
      stim_q     <= '0;
      pass_q     <= 1'b0;
      mm_q       <= '0;
      cc_q       <= '0;
      idx_q      <= '0;
      ffv_q      <= 1'b0;
      ff_idx_q   <= '0;
      fg_q       <= '0;
      fn_q       <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      vec_left_q <= vec_left_d;
      lfsr_q     <= lfsr_d;
      dut_rst_q  <= dut_rst_d;
      stim_q     <= stim_d;
      pass_q     <= pass_d;
      mm_q       <= mm_d;
      cc_q       <= cc_d;
      idx_q      <= idx_d;
      ffv_q      <= ffv_d;
      ff_idx_q   <= ff_idx_d;
      fg_q       <= fg_d;
      fn_q       <= fn_d;
    end
  end

  assign dut_rst          = dut_rst_q;
  assign stim             = stim_q;
  assign busy             = (state_q == S_SETTLE) || (state_q == S_APPLY);
  assign done             = (state_q == S_DONE);
  assign pass             = pass_q;
  assign mismatch_count   = mm_q;
  assign compare_count    = cc_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_index = ff_idx_q;
  assign first_golden     = fg_q;
  assign first_netlist    = fn_q;

endmodule
